// File: rtl/seq_rot_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_rot_alu_pkg                                           |
// | Brief    : Op codes, FSM states and helpers for the sequential ALU   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seq_rot_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SWC = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;
    localparam logic [2:0] OP_ROL = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_rot_op(input logic [2:0] op);
        return (op == OP_SWC) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_rot_alu_rot_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_rot_alu_rot_step                                      |
// | Brief    : Combinational WIDTH-bit rotator, dir=1 left, dir=0 right  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_rot_alu_rot_step #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [SHW-1:0]   s,
    input  logic             dir,
    output logic [WIDTH-1:0] rotated
);

    // Index arithmetic is SHW bits wide, so it wraps modulo WIDTH for free.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir) begin
                rotated[i] = value[SHW'(i) - s];
            end else begin
                rotated[i] = value[SHW'(i) + s];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_rot_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_rot_alu                                               |
// | Brief    : Multi-cycle ALU with iterative rotates behind valid/ready |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_rot_alu
    import seq_rot_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] c_STEP = (SHW+1)'(STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic [SHW-1:0]   r_rem;
    logic             r_dir;
    logic             r_zero;

    logic             w_accept;
    logic             w_start_rot;
    logic [SHW-1:0]   w_amt;
    logic             w_dir;
    logic [WIDTH-1:0] w_alu;
    logic [SHW-1:0]   w_s;
    logic             w_last;
    logic [WIDTH-1:0] w_rot;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_ROT) || (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;

    assign w_accept    = in_valid && in_ready;
    assign w_amt       = b[SHW-1:0];
    assign w_dir       = (op == OP_ROL) || ((op == OP_SWC) && b[0]);
    assign w_start_rot = is_rot_op(op) && (w_amt != '0);

    // Step size is min(STEP, remaining); compared one bit wider so STEP=WIDTH fits.
    assign w_s    = ({1'b0, r_rem} > c_STEP) ? c_STEP[SHW-1:0] : r_rem;
    assign w_last = (r_rem == w_s);

    // Rotates land here only with a zero amount, where the answer is a itself.
    always_comb begin
        w_alu = '0;
        case (op)
            OP_ADD:                 w_alu = a + b;
            OP_SUB:                 w_alu = a - b;
            OP_OR:                  w_alu = a | b;
            OP_AND:                 w_alu = a & b;
            OP_SWC, OP_ROR, OP_ROL: w_alu = a;
            default:                w_alu = '0;
        endcase
    end

    seq_rot_alu_rot_step #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_rot_step (
        .value   (r_work),
        .s       (w_s),
        .dir     (r_dir),
        .rotated (w_rot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_start_rot ? S_ROT : S_DONE;
                end
            end
            S_ROT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The result register is only written on completion, so a rotate in
    // flight never exposes an intermediate value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work   <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_dir    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_zero <= (a == b);
                        r_work <= a;
                        r_rem  <= w_amt;
                        r_dir  <= w_dir;
                        if (!w_start_rot) begin
                            r_result <= w_alu;
                        end
                    end
                end
                S_ROT: begin
                    r_work <= w_rot;
                    r_rem  <= r_rem - w_s;
                    if (w_last) begin
                        r_result <= w_rot;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_rot_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seq_rot_alu                                            |
// | Brief    : Self-checking bench, 32/1 and 16/4 instances vs. a model  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_seq_rot_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sel = 1'b0;

    int total = 0;
    int bad   = 0;

    logic        rdy32, ov32, z32, busy32;
    logic [31:0] res32;
    logic        rdy16, ov16, z16, busy16;
    logic [15:0] res16;
    logic        iv32, iv16;

    logic        m_in_ready, m_out_valid, m_zero, m_busy;
    logic [31:0] m_result;

    assign iv32 = in_valid & ~sel;
    assign iv16 = in_valid & sel;
    assign m_in_ready  = sel ? rdy16  : rdy32;
    assign m_out_valid = sel ? ov16   : ov32;
    assign m_zero      = sel ? z16    : z32;
    assign m_busy      = sel ? busy16 : busy32;
    assign m_result    = sel ? {16'h0, res16} : res32;

    always #5 clk = ~clk;

    seq_rot_alu #(.WIDTH(32), .STEP(1)) u32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32),
        .op(op), .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready),
        .result(res32), .zero(z32), .busy(busy32)
    );

    seq_rot_alu #(.WIDTH(16), .STEP(4)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(rdy16),
        .op(op), .a(a[15:0]), .b(b[15:0]), .out_valid(ov16), .out_ready(out_ready),
        .result(res16), .zero(z16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic int ref_amt(input int w, input logic [31:0] y);
        return int'(y & 32'(w - 1));
    endfunction

    // Reference: plain arithmetic on the operands, rotation via two shifts.
    function automatic logic [31:0] ref_res(input int w, input logic [2:0] o,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xv, r;
        int          amt;
        bit          left;
        xv  = {32'h0, x & wmask(w)};
        amt = ref_amt(w, y);
        case (o)
            3'd0: return (x + y) & wmask(w);
            3'd1: return (x - y) & wmask(w);
            3'd2: return (x | y) & wmask(w);
            3'd3: return (x & y) & wmask(w);
            3'd4: left = y[0];
            3'd5: left = 1'b0;
            3'd6: left = 1'b1;
            default: return 32'h0;
        endcase
        if (left) r = (xv << amt) | (xv >> (w - amt));
        else      r = (xv >> amt) | (xv << (w - amt));
        return r[31:0] & wmask(w);
    endfunction

    function automatic int ref_lat(input int w, input int step, input logic [2:0] o,
                                   input logic [31:0] y);
        int amt;
        amt = ref_amt(w, y);
        if ((o >= 3'd4) && (o <= 3'd6) && (amt != 0)) return 1 + (amt + step - 1) / step;
        return 1;
    endfunction

    // One full transaction on the selected instance, with noise on in_valid
    // and out_ready while the unit is busy.
    task automatic run_op(input bit s, input logic [2:0] op_i, input logic [31:0] ai,
                          input logic [31:0] bi, input logic [31:0] exp_res,
                          input bit exp_zero, input int exp_lat, input string tag);
        int lat;
        bit stall_ok;
        sel = s; op = op_i; a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, ".ready_pre"}, 32'(m_in_ready), 32'd1);
        @(posedge clk); #1;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        lat = 1;
        stall_ok = 1'b1;
        while (!m_out_valid && lat < 100) begin
            if (m_in_ready !== 1'b0 || m_busy !== 1'b1) stall_ok = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".stall"}, 32'(stall_ok), 32'd1);
        check({tag, ".result"}, m_result, exp_res);
        check({tag, ".zero"}, 32'(m_zero), 32'(exp_zero));
        check({tag, ".ready_done"}, 32'(m_in_ready), 32'd0);
        check({tag, ".busy_done"}, 32'(m_busy), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_post"}, 32'(m_out_valid), 32'd0);
        check({tag, ".ready_post"}, 32'(m_in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          w, st, lat;
        bit          s;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sel = 1'b0;
        check("rst.in_ready", 32'(m_in_ready), 32'd1);
        check("rst.out_valid", 32'(m_out_valid), 32'd0);
        check("rst.result", m_result, 32'h0);
        check("rst.zero", 32'(m_zero), 32'd0);
        check("rst.busy", 32'(m_busy), 32'd0);

        // Directed cases, WIDTH=32 STEP=1
        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, "add_wrap");
        run_op(1'b0, 3'd4, 32'h8000_0001, 32'd4, 32'h1800_0000, 1'b0, 5, "swc_even");
        run_op(1'b0, 3'd4, 32'h8000_0001, 32'd3, 32'h0000_000C, 1'b0, 4, "swc_odd");
        run_op(1'b0, 3'd6, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 1, "rol_zero");
        run_op(1'b0, 3'd2, 32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 1'b1, 1, "or_eq");
        run_op(1'b0, 3'd7, 32'h0000_0003, 32'h0000_0005, 32'h0, 1'b0, 1, "undef");
        run_op(1'b0, 3'd5, 32'h0000_00FF, 32'hFFFF_FFE4, 32'hF000_000F, 1'b0, 5, "ror_hib");

        // Directed cases, WIDTH=16 STEP=4
        run_op(1'b1, 3'd5, 32'h1234, 32'd6, 32'hD048, 1'b0, 3, "w16_ror");
        run_op(1'b1, 3'd1, 32'h00AA, 32'h00AA, 32'h0, 1'b1, 1, "w16_sub_eq");
        run_op(1'b1, 3'd6, 32'h8001, 32'd15, 32'hC000, 1'b0, 5, "w16_rol15");

        // Backpressure: result held, new request ignored until IDLE
        sel = 1'b0; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp.latency", 32'(lat), 32'd9);
        check("bp.result", m_result, 32'hEFDE_ADBE);
        op = 3'd0; a = 32'd5; b = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp.hold_result", m_result, 32'hEFDE_ADBE);
            check("bp.hold_zero", 32'(m_zero), 32'd0);
            check("bp.hold_ready", 32'(m_in_ready), 32'd0);
            check("bp.hold_valid", 32'(m_out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.idle_ready", 32'(m_in_ready), 32'd1);
        check("bp.idle_valid", 32'(m_out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.pending_valid", 32'(m_out_valid), 32'd1);
        check("bp.pending_result", m_result, 32'd10);
        check("bp.pending_zero", 32'(m_zero), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a long rotate
        sel = 1'b0; op = 3'd5; a = 32'h1357_9BDF; b = 32'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid.busy", 32'(m_busy), 32'd1);
        check("mid.out_valid", 32'(m_out_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.out_valid", 32'(m_out_valid), 32'd0);
        check("abort.result", m_result, 32'h0);
        check("abort.busy", 32'(m_busy), 32'd0);
        check("abort.in_ready", 32'(m_in_ready), 32'd1);

        // Randomized transactions on both instances against the model
        for (int k = 0; k < 60; k++) begin
            s  = 1'(k % 2);
            w  = s ? 16 : 32;
            st = s ? 4 : 1;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op(s, ro, ra, rb, ref_res(w, ro, ra, rb),
                   ((ra ^ rb) & wmask(w)) == 32'h0, ref_lat(w, st, ro, rb), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
